// File: rtl/mmio_pkg.sv
// Shared constants for the data-side bus target: MMIO register offsets,
// STATUS word layout and the address-decode region type.
package mmio_pkg;

  localparam logic [7:0] OFF_TXDATA = 8'h00;
  localparam logic [7:0] OFF_STATUS = 8'h04;
  localparam logic [7:0] OFF_CYCLES = 8'h08;
  localparam logic [7:0] OFF_CTRL   = 8'h0C;

  localparam int ST_COUNT_LSB = 0;
  localparam int ST_COUNT_W   = 7;
  localparam int ST_EMPTY     = 7;
  localparam int ST_FULL      = 8;
  localparam int ST_OVF       = 9;

  typedef enum logic [1:0] {REG_RAM, REG_MMIO, REG_NONE} region_t;

  function automatic logic [31:0] pack_status(input logic ovf, input logic full,
                                              input logic empty, input logic [6:0] cnt);
    logic [31:0] s;
    s = '0;
    s[ST_OVF]   = ovf;
    s[ST_FULL]  = full;
    s[ST_EMPTY] = empty;
    s[ST_COUNT_LSB +: ST_COUNT_W] = cnt;
    return s;
  endfunction

endpackage

// File: rtl/tx_fifo.sv
// Synchronous byte FIFO with sticky overflow; a push into a full FIFO is
// accepted only when a pop frees a slot on the same edge.
module tx_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [7:0]             push_data,
  input  logic                   pop,
  input  logic                   clr_ovf,
  output logic [7:0]             head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          do_push, do_pop;

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign overflow = overflow_q;
  // Storage is registered, so the head stays stable while the consumer stalls.
  assign head     = empty ? 8'h00 : mem_q[rd_ptr_q];

  always_comb begin
    do_pop     = pop & ~empty;
    do_push    = push & (~full | do_pop);
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (push & full & ~do_pop) overflow_d = 1'b1;
    else if (clr_ovf)          overflow_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/mmio_bridge.sv
// Data-side bus target: word RAM plus an MMIO window holding a TX FIFO,
// a free-running cycle counter and a status word. Loads are combinational.
module mmio_bridge
  import mmio_pkg::*;
#(
  parameter int          RAM_WORDS  = 256,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] MMIO_BASE  = 32'hFFFF_FF00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] data_adr,
  input  logic [31:0] write_data,
  input  logic        mem_write,
  output logic [31:0] read_data,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        bus_err
);

  localparam int AW = $clog2(RAM_WORDS);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]   ram_q [RAM_WORDS];
  region_t       region;
  logic [7:0]    offset;
  logic [AW-1:0] ram_idx;
  logic [31:0]   cycles_q, cycles_d;
  logic [31:0]   prev_adr_q, prev_adr_d;
  logic          bus_err_q, bus_err_d;
  logic          push, pop, clr_ovf;
  logic          fifo_full, fifo_empty, fifo_ovf;
  logic [CW-1:0] fifo_count;
  logic [6:0]    count7;

  always_comb begin
    offset  = {data_adr[7:2], 2'b00};
    ram_idx = data_adr[AW+1:2];
    if (data_adr[31:AW+2] == '0)                 region = REG_RAM;
    else if (data_adr[31:8] == MMIO_BASE[31:8])  region = REG_MMIO;
    else                                         region = REG_NONE;
  end

  assign count7 = 7'(fifo_count);

  always_comb begin
    read_data = '0;
    case (region)
      REG_RAM:  read_data = ram_q[ram_idx];
      REG_MMIO: begin
        if (offset == OFF_STATUS)      read_data = pack_status(fifo_ovf, fifo_full, fifo_empty, count7);
        else if (offset == OFF_CYCLES) read_data = cycles_q;
      end
      default:  read_data = '0;
    endcase
  end

  // bus_err only fires on a store or a fresh address, never while idling on one.
  always_comb begin
    push       = mem_write && (region == REG_MMIO) && (offset == OFF_TXDATA);
    clr_ovf    = mem_write && (region == REG_MMIO) && (offset == OFF_CTRL) && write_data[0];
    cycles_d   = cycles_q + 32'd1;
    prev_adr_d = data_adr;
    bus_err_d  = (region == REG_NONE) && (mem_write || (data_adr != prev_adr_q));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycles_q   <= '0;
      prev_adr_q <= '0;
      bus_err_q  <= 1'b0;
    end else begin
      cycles_q   <= cycles_d;
      prev_adr_q <= prev_adr_d;
      bus_err_q  <= bus_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_write && (region == REG_RAM)) ram_q[ram_idx] <= write_data;
  end

  assign tx_valid = ~fifo_empty;
  assign pop      = tx_valid & tx_ready;
  assign bus_err  = bus_err_q;

  tx_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (write_data[7:0]),
    .pop       (pop),
    .clr_ovf   (clr_ovf),
    .head      (tx_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .overflow  (fifo_ovf)
  );

endmodule
